fetch_stage: RTL and testbench

- PC register and instruction-fetch stage; sits directly upstream of the next-PC logic.
- Holds the current PC and fetches the instruction word at that PC from instruction memory over a req/gnt/rvalid handshake.
- Presents the PC, PC+1 and the instruction to decode / next-PC logic with a valid/ready handshake.
- Loads the next-PC result when the instruction is consumed.

---
 rtl/fetch_stage_pkg.sv | 22 ++
 rtl/fetch_timeout_ctr.sv | 45 ++++
 rtl/fetch_stage.sv | 120 ++++++++++++
 tb/tb_fetch_stage.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding,
// reset PC default and instruction width.
package fetch_stage_pkg;

  // Width of an instruction word as returned by instruction memory.
  localparam int unsigned INSN_W = 32;

  // Width of the architectural PC.
  localparam int unsigned PC_W = 32;

  // PC loaded on reset unless the instance overrides it.
  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'd0;

  // Fetch FSM states. S_ERR is terminal until reset.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_ERR  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts cycles spent waiting for imem read data after a grant. The terminal
// output flags that the increment happening this cycle brings the count to
// TIMEOUT-1, so the owner can react on the same edge the limit is reached.
module fetch_timeout_ctr
  import fetch_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16  // must be >= 2
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW:0] LIMIT = (CW + 1)'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0]   cnt_inc;

  // One extra bit so the compare is immune to wrap at the top of the range.
  assign cnt_inc  = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};
  assign terminal = (cnt_inc == LIMIT);

  // Clear wins over enable; otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_inc[CW-1:0];
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// PC register and instruction-fetch stage. Fetches the word at the current PC
// over a req/gnt/rvalid handshake, holds it for decode with valid/ready, and
// loads the next-PC result when the instruction is consumed.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic [31:0]       next_pc_in,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              insn_valid,
  input  logic              insn_ready,
  output logic [31:0]       insn,
  output logic [31:0]       pc_out,
  output logic [31:0]       pc_plus_1,
  output logic              fetch_err,
  output logic [31:0]       fetch_count
);

  fetch_state_e state_q, state_d;

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [INSN_W-1:0] insn_q, insn_d;
  logic              err_q, err_d;
  logic [31:0]       count_q, count_d;

  logic tmo_clear;
  logic tmo_enable;
  logic tmo_hit;

  // Counter restarts on the grant and advances on every WAIT cycle without data.
  assign tmo_clear  = (state_q == S_REQ) && fetch_en && imem_gnt;
  assign tmo_enable = (state_q == S_WAIT) && !imem_rvalid;

  fetch_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clock    (clock),
    .reset    (reset),
    .clear    (tmo_clear),
    .enable   (tmo_enable),
    .terminal (tmo_hit)
  );

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    insn_d     = insn_q;
    err_d      = err_q;
    count_d    = count_q;
    imem_req   = 1'b0;
    insn_valid = 1'b0;

    unique case (state_q)
      S_REQ: begin
        // fetch_en only gates new requests; a stray gnt or rvalid is ignored here.
        imem_req = fetch_en;
        if (fetch_en && imem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          insn_d  = imem_rdata;
          state_d = S_HOLD;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end
      end
      S_HOLD: begin
        insn_valid = 1'b1;
        if (insn_ready) begin
          pc_d    = next_pc_in;
          count_d = count_q + 32'd1;
          state_d = S_REQ;
        end
      end
      S_ERR: begin
        // Terminal: nothing leaves this state except reset.
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      insn_q  <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      insn_q  <= insn_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  // Upper PC bits are dropped, so the word address wraps with the memory size.
  assign imem_addr   = pc_q[ADDR_W-1:0];
  assign pc_out      = pc_q;
  assign pc_plus_1   = pc_q + 32'd1;
  assign insn        = insn_q;
  assign fetch_err   = err_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a transaction-level reference model
// checked every cycle, plus literal expectations on key cycles.
module tb_fetch_stage;

  localparam int unsigned TMO = 16;

  logic        clock;
  logic        reset;
  logic        fetch_en;
  logic [31:0] next_pc_in;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        insn_ready;

  logic        imem_req;
  logic [11:0] imem_addr;
  logic        insn_valid;
  logic [31:0] insn;
  logic [31:0] pc_out;
  logic [31:0] pc_plus_1;
  logic        fetch_err;
  logic [31:0] fetch_count;

  // Second instance starting at the top of the address space, fed the same
  // handshake and always following its own pc_plus_1.
  logic        w_imem_req;
  logic [11:0] w_imem_addr;
  logic        w_insn_valid;
  logic [31:0] w_insn;
  logic [31:0] w_pc_out;
  logic [31:0] w_pc_plus_1;
  logic        w_fetch_err;
  logic [31:0] w_fetch_count;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_on   = 1'b0;

  fetch_stage #(
    .RESET_PC (32'd0),
    .ADDR_W   (12),
    .TIMEOUT  (TMO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .fetch_en    (fetch_en),
    .next_pc_in  (next_pc_in),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .insn_valid  (insn_valid),
    .insn_ready  (insn_ready),
    .insn        (insn),
    .pc_out      (pc_out),
    .pc_plus_1   (pc_plus_1),
    .fetch_err   (fetch_err),
    .fetch_count (fetch_count)
  );

  fetch_stage #(
    .RESET_PC (32'hFFFF_FFFF),
    .ADDR_W   (12),
    .TIMEOUT  (TMO)
  ) dut_wrap (
    .clock       (clock),
    .reset       (reset),
    .fetch_en    (fetch_en),
    .next_pc_in  (w_pc_plus_1),
    .imem_req    (w_imem_req),
    .imem_addr   (w_imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .insn_valid  (w_insn_valid),
    .insn_ready  (insn_ready),
    .insn        (w_insn),
    .pc_out      (w_pc_out),
    .pc_plus_1   (w_pc_plus_1),
    .fetch_err   (w_fetch_err),
    .fetch_count (w_fetch_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks what the stage owns: PC, held word, consume count, error flag,
  // whether a granted read is outstanding (and for how long), whether a word
  // is being held, and whether the stage has given up.
  logic [31:0] m_pc, m_insn, m_count;
  bit          m_err, m_have, m_dead;
  int          m_since;  // cycles waited on an outstanding read, -1 if none

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_pc    <= 32'd0;
      m_insn  <= 32'd0;
      m_count <= 32'd0;
      m_err   <= 1'b0;
      m_have  <= 1'b0;
      m_dead  <= 1'b0;
      m_since <= -1;
    end else if (!m_dead) begin
      if (m_have) begin
        if (insn_ready) begin
          m_pc    <= next_pc_in;
          m_count <= m_count + 32'd1;
          m_have  <= 1'b0;
        end
      end else if (m_since >= 0) begin
        if (imem_rvalid) begin
          m_insn  <= imem_rdata;
          m_have  <= 1'b1;
          m_since <= -1;
        end else if (m_since + 1 == TMO - 1) begin
          m_err   <= 1'b1;
          m_dead  <= 1'b1;
          m_since <= -1;
        end else begin
          m_since <= m_since + 1;
        end
      end else if (fetch_en && imem_gnt) begin
        m_since <= 0;
      end
    end
  end

  // Every-cycle comparison against the model, well clear of the rising edge.
  always @(negedge clock) begin
    #3;
    if (cmp_on) begin
      check("m_req",   {31'd0, imem_req},
            {31'd0, !m_dead && !m_have && (m_since < 0) && fetch_en});
      check("m_addr",  {20'd0, imem_addr}, {20'd0, m_pc[11:0]});
      check("m_valid", {31'd0, insn_valid}, {31'd0, m_have});
      check("m_insn",  insn, m_insn);
      check("m_pc",    pc_out, m_pc);
      check("m_pc1",   pc_plus_1, m_pc + 32'd1);
      check("m_err",   {31'd0, fetch_err}, {31'd0, m_err});
      check("m_count", fetch_count, m_count);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic en, input logic gnt, input logic rv,
                       input logic [31:0] rd, input logic rdy, input logic [31:0] npc);
    @(negedge clock);
    fetch_en    = en;
    imem_gnt    = gnt;
    imem_rvalid = rv;
    imem_rdata  = rd;
    insn_ready  = rdy;
    next_pc_in  = npc;
  endtask

  // One zero-wait fetch at exp_pc, optionally stalled in the hold phase.
  task automatic fetch_one(input logic [31:0] data, input int stall,
                           input logic [31:0] npc, input logic [31:0] exp_pc);
    drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    #3;
    check("req_issued", {31'd0, imem_req}, 32'd1);
    check("req_addr", {20'd0, imem_addr}, {20'd0, exp_pc[11:0]});
    drive(1'b1, 1'b0, 1'b1, data, 1'b0, 32'd0);
    for (int i = 0; i < stall; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      #3;
      check("stall_valid", {31'd0, insn_valid}, 32'd1);
      check("stall_noreq", {31'd0, imem_req}, 32'd0);
      check("stall_pc", pc_out, exp_pc);
      check("stall_pc1", pc_plus_1, exp_pc + 32'd1);
    end
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, npc);
    #3;
    check("hold_insn", insn, data);
    check("hold_pc", pc_out, exp_pc);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    #1 reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    reset = 1'b1;
  endtask

  initial begin
    reset       = 1'b1;
    fetch_en    = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    insn_ready  = 1'b0;
    next_pc_in  = 32'd0;
    #1 reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    reset  = 1'b1;
    cmp_on = 1'b1;

    // Reset state, both instances.
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    #3;
    check("rst_pc", pc_out, 32'd0);
    check("rst_insn", insn, 32'd0);
    check("rst_count", fetch_count, 32'd0);
    check("rst_err", {31'd0, fetch_err}, 32'd0);
    check("wrap_rst_pc", w_pc_out, 32'hFFFF_FFFF);
    check("wrap_rst_pc1", w_pc_plus_1, 32'd0);
    check("wrap_rst_addr", {20'd0, w_imem_addr}, 32'h0000_0FFF);

    // Straight-line fetches at 0, 1, 2.
    fetch_one(32'h0800_0005, 0, 32'd1, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    #3;
    check("wrap_addr_after", {20'd0, w_imem_addr}, 32'd0);
    check("wrap_pc_after", w_pc_out, 32'd0);
    check("wrap_count", w_fetch_count, 32'd1);
    check("wrap_insn", w_insn, 32'h0800_0005);
    check("wrap_flags", {29'd0, w_imem_req, w_insn_valid, w_fetch_err}, 32'd4);
    fetch_one(32'h0800_0005, 0, 32'd2, 32'd1);
    fetch_one(32'h0800_0005, 0, 32'd4, 32'd2);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    #3;
    check("count_3", fetch_count, 32'd3);

    // Backpressure at pc 4, then jump to 20.
    fetch_one(32'h1234_0004, 5, 32'd20, 32'd4);
    fetch_one(32'h0000_0014, 0, 32'hFFFF_FFFF, 32'd20);

    // Top of address space: pc+1 wraps to 0, address truncates.
    fetch_one(32'hCAFE_0000, 0, 32'd0, 32'hFFFF_FFFF);
    check("wrap_pc1_zero", pc_plus_1, 32'd0);

    // fetch_en low with gnt pulsing: nothing moves.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      #3;
      check("en_low_req", {31'd0, imem_req}, 32'd0);
      check("en_low_pc", pc_out, 32'd0);
      check("en_low_valid", {31'd0, insn_valid}, 32'd0);
    end
    fetch_one(32'h0000_0777, 0, 32'd7, 32'd0);

    // Timeout: grant, then withhold rvalid.
    drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    for (int k = 0; k <= 15; k++) begin
      drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      #3;
      check((k < 15) ? "tmo_err_low" : "tmo_err_rise", {31'd0, fetch_err},
            (k < 15) ? 32'd0 : 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 32'h5555_5555, 1'b1, 32'd9);
      #3;
      check("err_noreq", {31'd0, imem_req}, 32'd0);
      check("err_novalid", {31'd0, insn_valid}, 32'd0);
      check("err_sticky", {31'd0, fetch_err}, 32'd1);
      check("err_count", fetch_count, 32'd7);
    end

    // Reset mid-read, then a stale rvalid that must be dropped.
    pulse_reset();
    drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    #1 reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    #3;
    check("stale_insn", insn, 32'd0);
    check("stale_valid", {31'd0, insn_valid}, 32'd0);
    check("stale_pc", pc_out, 32'd0);
    check("stale_req", {31'd0, imem_req}, 32'd1);
    fetch_one(32'h0000_00AA, 0, 32'd1, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    #3;
    check("post_rst_count", fetch_count, 32'd1);
    check("post_rst_pc", pc_out, 32'd1);

    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1);
  end

endmodule
